memory16x32_ctrl: RTL and testbench
===================================

# memory16x32_ctrl

Burst access controller that drives the single-port 16x32 memory from the initiator side. It accepts one command at a time: read or write, base address and length 1–16. It then sequences the memory's `Data_in`/`Address`/`EN` port one word per cycle and collects `Data_out`/`Valid_out`. Upstream logic streams write data through a valid/ready handshake and receives read data as a valid-qualified stream.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 4, memory address width
- MEMO_DEPTH, 1<<ADDR_WIDTH, number of words; also the maximum burst length

Ports:
- CLK  in  1  clock; all logic is on the rising edge
- RST  in  1  reset, asynchronous, active-low
- Start  in  1  command strobe; sampled only in IDLE
- Op  in  1  command type; 1 = write, 0 = read
- Base_addr  in  ADDR_WIDTH  first address of the burst
- Length  in  ADDR_WIDTH+1  number of words; legal range 1..MEMO_DEPTH
- Wr_data  in  DATA_WIDTH  write beat data
- Wr_valid  in  1  write beat offered
- Wr_ready  out  1  write beat accepted when Wr_valid && Wr_ready
- Rd_data  out  DATA_WIDTH  read beat data
- Rd_valid  out  1  read beat strobe; no backpressure
- Busy  out  1  a command is in progress
- Done  out  1  one-cycle pulse on command completion
- Err  out  1  one-cycle pulse on command or protocol error
- Mem_Data_in  out  DATA_WIDTH  to memory Data_in
- Mem_Address  out  ADDR_WIDTH  to memory Address
- Mem_EN  out  1  to memory EN; 1 = write, 0 = read
- Mem_Data_out  in  DATA_WIDTH  from memory Data_out
- Mem_Valid_out  in  1  from memory Valid_out

## Operation
- **Memory behaviour it targets:** on each posedge, EN=1 writes `mem[Address]` and clears Valid_out. EN=0 registers `mem[Address]` onto Data_out and sets Valid_out. Read latency is therefore 1 cycle.
- **FSM states:** IDLE, WR, RD, DRAIN. `Busy = (state != IDLE)`.
- **IDLE:**
  - Start=1 with a legal Length latches Base_addr, Length and Op, clears the beat counter k, and moves to WR (Op=1) or RD (Op=0).
  - Start=1 with Length=0 or Length>MEMO_DEPTH is rejected: state stays IDLE, Err pulses next cycle, and there is no memory access.
- **Addressing:** `Mem_Address = (base + k) mod MEMO_DEPTH`, i.e. the low ADDR_WIDTH bits. Bursts wrap past MEMO_DEPTH-1 to 0.
- **WR state:**
  - Wr_ready=1.
  - Mem_EN, Mem_Data_in = Wr_data and Mem_Address are combinational from the handshake: `Mem_EN = Wr_valid`.
  - Each handshake increments k. A cycle with Wr_valid=0 is a stall: Mem_EN=0 and no write.
  - After the L-th handshake the FSM goes to IDLE.
- **RD state:**
  - Mem_EN=0; issues address base+k each cycle and increments k, with no stalls.
  - After L issues the FSM goes to DRAIN.
- **Read return path:**
  - A beat expected from an address issued in cycle t is checked in cycle t+1.
  - If Mem_Valid_out=1, Mem_Data_out is registered and Rd_valid=1 in cycle t+2.
  - If Mem_Valid_out=0, no Rd_valid is produced for that beat, Err pulses in cycle t+2, and the burst continues.
- **DRAIN:** lasts until the last expected beat has been checked, then goes to IDLE.
- **Done:** pulses in the first IDLE cycle after WR or DRAIN. For reads this is the same cycle as the final Rd_valid.
- Start is ignored while Busy=1. A new Start is accepted in the same cycle Done is high.
- Outside WR: Mem_EN=0, Mem_Data_in=0, Wr_ready=0. In IDLE, Mem_Address=0. Reads the memory performs while idle are ignored.

## Timing
- **Reset:** RST=0 asynchronously forces IDLE, k=0, and clears the latched command and pipeline.
  - Outputs during reset: Busy=0, Done=0, Err=0, Rd_valid=0, Rd_data=0, Wr_ready=0, Mem_EN=0, Mem_Address=0, Mem_Data_in=0.
  - Reset mid-burst aborts without a Done pulse. Memory contents already written stay written.
- **Write timing:** Start sampled at posedge T0. WR runs from cycle T0+1. A zero-stall burst writes in cycles T0+1..T0+L, and Done/IDLE follow in cycle T0+L+1.
- **Read timing:** Start sampled at posedge T0. Addresses are issued in cycles T0+1..T0+L. Beat k appears on Rd_valid in cycle T0+3+k.
  - The last beat and Done both land in cycle T0+L+2.
  - Busy is high in cycles T0+1..T0+L+1.
- Throughput is one word per cycle in both directions. Back-to-back commands are separated by no idle cycle beyond the Done cycle.

## Test plan
- **Reset:** drive RST=0 mid-simulation -> all outputs are 0 within the same time step without waiting for CLK; Busy stays 0 until a Start after release.
- **Write with stall:** Start, Op=1, Base=2, L=4, data 0xA0..0xA3, Wr_valid low for 2 cycles between beats 1 and 2 -> exactly 4 Mem_EN=1 cycles at addresses 2,3,4,5; Done one cycle after the 4th handshake.
- **Read-back:** Start, Op=0, Base=2, L=4 -> Rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles T0+3..T0+6; Done in T0+6; Mem_EN never 1.
- **Wrap-around:** write Base=14, L=4 -> writes at addresses 14,15,0,1. A read with Base=14, L=4 returns the same words in order.
- **Illegal length:** Start with Length=0, then with Length=17 -> each gives a single-cycle Err pulse, Busy=0 throughout, no Mem_EN, no Done.
- **Reset mid-read:** read L=8, assert RST=0 after 2 Rd_valid beats -> Rd_valid drops immediately, no Done; after release a fresh read of L=1 completes normally with Done in T0+3.

Source files
------------

// File: rtl/memory16x32_ctrl.sv
// memory16x32_ctrl: burst read/write sequencer for a single-port 16x32 memory with 1-cycle read latency
module memory16x32_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEMO_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Op,
  input  logic [ADDR_WIDTH-1:0] Base_addr,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic [DATA_WIDTH-1:0] Wr_data,
  input  logic                  Wr_valid,
  output logic                  Wr_ready,
  output logic [DATA_WIDTH-1:0] Rd_data,
  output logic                  Rd_valid,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [DATA_WIDTH-1:0] Mem_Data_in,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic                  Mem_EN,
  input  logic [DATA_WIDTH-1:0] Mem_Data_out,
  input  logic                  Mem_Valid_out
);
  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MEMO_DEPTH);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0] len, k;
  logic legal, hs, last, chk;
  assign legal = Length != '0 && Length <= MAX_LEN;
  assign hs = state == WR && Wr_valid;
  assign last = k == len - 1'b1;
  assign Busy = state != IDLE;
  assign Wr_ready = state == WR;
  assign Mem_EN = hs;
  assign Mem_Data_in = state == WR ? Wr_data : '0;
  assign Mem_Address = (state == WR || state == RD) ? base + k[ADDR_WIDTH-1:0] : '0;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = (Start && legal) ? (Op ? WR : RD) : IDLE;
      WR:    state_nx = (hs && last) ? IDLE : WR;
      RD:    state_nx = last ? DRAIN : RD;
      DRAIN: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nx;
  // chk marks the cycle in which the memory answers the address issued one cycle earlier
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      base <= '0;
      len <= '0;
      k <= '0;
      chk <= 1'b0;
      Rd_valid <= 1'b0;
      Rd_data <= '0;
      Done <= 1'b0;
      Err <= 1'b0;
    end else begin
      if (state == IDLE && Start && legal) begin
        base <= Base_addr;
        len <= Length;
      end
      k <= state == IDLE ? '0 : (hs || state == RD) ? k + 1'b1 : k;
      chk <= state == RD;
      Rd_valid <= chk && Mem_Valid_out;
      if (chk && Mem_Valid_out) Rd_data <= Mem_Data_out;
      Done <= (hs && last) || state == DRAIN;
      Err <= (state == IDLE && Start && !legal) || (chk && !Mem_Valid_out);
    end
endmodule

// File: tb/tb_memory16x32_ctrl.sv
// tb_memory16x32_ctrl: table-driven and random bursts against a word-array reference of the memory
module tb_memory16x32_ctrl;
  logic CLK = 1'b0, RST = 1'b0, Start = 1'b0, Op = 1'b0, Wr_valid = 1'b0;
  logic [3:0] Base_addr = '0;
  logic [4:0] Length = '0;
  logic [31:0] Wr_data = '0;
  logic Wr_ready, Rd_valid, Busy, Done, Err, Mem_EN;
  logic [31:0] Rd_data, Mem_Data_in;
  logic [3:0] Mem_Address;
  logic [31:0] mem [16];
  logic [31:0] mem_do;
  logic mem_vo = 1'b0;
  logic drop_en = 1'b0;
  logic [3:0] drop_addr = '0;
  logic [31:0] ref_mem [16];
  int n_chk = 0, n_fail = 0;

  typedef struct {
    bit op; int base; int len; int stall_at; int stall_n; int drop_k; logic [31:0] data0; int exp_beats;
  } vec_t;
  vec_t vt [9];

  memory16x32_ctrl dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Base_addr(Base_addr), .Length(Length),
    .Wr_data(Wr_data), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready), .Rd_data(Rd_data),
    .Rd_valid(Rd_valid), .Busy(Busy), .Done(Done), .Err(Err), .Mem_Data_in(Mem_Data_in),
    .Mem_Address(Mem_Address), .Mem_EN(Mem_EN), .Mem_Data_out(mem_do), .Mem_Valid_out(mem_vo)
  );

  always #5 CLK = ~CLK;

  // memory under control; drop_en makes one address answer without Valid_out
  always @(posedge CLK)
    if (Mem_EN) begin
      mem[Mem_Address] <= Mem_Data_in;
      mem_vo <= 1'b0;
    end else begin
      mem_do <= mem[Mem_Address];
      mem_vo <= !(drop_en && Mem_Address == drop_addr);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {Busy, Done, Err, Rd_valid, Wr_ready, Mem_EN, Mem_Address}, 0);
    chk({tag, "_rdd"}, Rd_data, 0);
    chk({tag, "_din"}, Mem_Data_in, 0);
  endtask

  task automatic run(input bit op, input int base, input int len, input int stall_at, input int stall_n,
                     input int drop_k, input logic [31:0] data0, input int exp_beats);
    logic [31:0] wd [16];
    int b, stalls, last_hs, ncyc, k, n_obs;
    bit legal, busy_wr, hs, exp_rv;
    for (int i = 0; i < 16; i++) wd[i] = data0 != 0 ? data0 + 32'(i) : $urandom;
    legal = len >= 1 && len <= 16;
    drop_en = legal && !op && drop_k >= 0;
    drop_addr = 4'(base + drop_k);
    b = 0; stalls = stall_n; last_hs = -10; n_obs = 0;
    ncyc = !legal ? 3 : op ? len + stall_n + 2 : len + 3;
    @(posedge CLK); #1;
    Start = 1'b1; Op = op; Base_addr = 4'(base); Length = 5'(len);
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      busy_wr = op && legal && b < len;
      Wr_valid = busy_wr && !(b == stall_at && stalls > 0);
      if (busy_wr && !Wr_valid) stalls--;
      Wr_data = Wr_valid ? wd[b] : $urandom;
      if (!op && legal) begin
        Start = c == 2;
        Op = 1'b1;
        Length = 5'd5;
      end
      @(negedge CLK);
      k = c - 3;
      hs = busy_wr && Wr_valid;
      exp_rv = !op && legal && k >= 0 && k < len && k != drop_k;
      chk("busy", Busy, legal && (op ? b < len : c <= len + 1));
      chk("wr_ready", Wr_ready, busy_wr);
      chk("mem_en", Mem_EN, hs);
      chk("done", Done, legal && (op ? c == last_hs + 1 : c == len + 2));
      chk("err", Err, legal ? (!op && drop_k >= 0 && k == drop_k) : c == 1);
      chk("rd_valid", Rd_valid, exp_rv);
      if (exp_rv) chk("rd_data", Rd_data, ref_mem[(base + k) % 16]);
      if (!op && legal && c <= len) chk("rd_addr", Mem_Address, (base + c - 1) % 16);
      if (!busy_wr) chk("din_idle", Mem_Data_in, 0);
      if (hs) begin
        chk("wr_addr", Mem_Address, (base + b) % 16);
        chk("wr_data", Mem_Data_in, wd[b]);
        ref_mem[(base + b) % 16] = wd[b];
        b++;
        if (b == len) last_hs = c;
      end
      n_obs += int'(Rd_valid) + int'(Mem_EN);
      @(posedge CLK); #1;
    end
    Start = 1'b0; Wr_valid = 1'b0; drop_en = 1'b0;
    chk("beats", n_obs, exp_beats);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op, len, base, sa, sn, dk, beats, t;
    vt[0] = '{1, 0, 16, 0, 0, -1, 32'h0, 16};
    vt[1] = '{1, 2, 4, 2, 2, -1, 32'hA0, 4};
    vt[2] = '{0, 2, 4, 0, 0, -1, 32'h0, 4};
    vt[3] = '{1, 14, 4, 1, 1, -1, 32'h0, 4};
    vt[4] = '{0, 14, 4, 0, 0, -1, 32'h0, 4};
    vt[5] = '{0, 3, 0, 0, 0, -1, 32'h0, 0};
    vt[6] = '{1, 3, 17, 0, 0, -1, 32'h0, 0};
    vt[7] = '{0, 5, 16, 0, 0, 3, 32'h0, 15};
    vt[8] = '{0, 7, 1, 0, 0, -1, 32'h0, 1};
    #2 chk_reset_outs("rst0");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 9; i++)
      run(vt[i].op, vt[i].base, vt[i].len, vt[i].stall_at, vt[i].stall_n, vt[i].drop_k, vt[i].data0, vt[i].exp_beats);
    for (int i = 0; i < 25; i++) begin
      op = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, 15));
      len = int'($urandom_range(0, 17));
      sa = len > 0 ? int'($urandom_range(0, len - 1)) : 0;
      sn = int'($urandom_range(0, 3));
      dk = ($urandom_range(0, 3) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
      beats = (len < 1 || len > 16) ? 0 : op != 0 ? len : len - (dk >= 0 ? 1 : 0);
      run(op != 0, base, len, sa, sn, dk, 32'h0, beats);
    end
    @(posedge CLK); #1;
    Start = 1'b1; Op = 1'b0; Base_addr = 4'd0; Length = 5'd8;
    @(posedge CLK); #1;
    Start = 1'b0;
    beats = 0; t = 0;
    while (beats < 2 && t < 20) begin
      @(negedge CLK);
      t++;
      if (Rd_valid === 1'b1) beats++;
    end
    chk("mid_beats", beats, 2);
    RST = 1'b0;
    #1 chk_reset_outs("rst_mid");
    repeat (2) begin
      @(negedge CLK);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("post_busy", Busy, 0);
    chk("post_done", Done, 0);
    run(1'b0, 3, 1, 0, 0, -1, 32'h0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
